dual_pe_mem_arbiter: RTL and testbench
======================================

// Module: dual_pe_mem_arbiter
// PURPOSE
//  Downstream of the two processing elements' load/store paths: merges PE1/PE2 data-memory requests
//  onto one single-port shared data memory (1-cycle read latency).
//  Round-robin arbitration, at most one access per cycle, read data returned to the owning PE.
//  Saturating per-PE stall counters for performance debug.
// PARAMETERS
//  ADDR_W   32  byte-address width of PE and memory address buses
//  DATA_W   32  data width of write/read buses
//  CNT_W    16  width of each saturating stall counter
// PORTS
//  clk            in   1       single clock; all state updates on rising edge
//  rst            in   1       reset, synchronous, active-high
//  pe1_req        in   1       PE1 access request; held with pe1_we/addr/wdata stable until pe1_ready
//  pe1_we         in   1       1 = store, 0 = load
//  pe1_addr       in   ADDR_W  PE1 byte address
//  pe1_wdata      in   DATA_W  PE1 store data
//  pe1_ready      out  1       PE1 request granted this cycle
//  pe1_rvalid     out  1       PE1 load data valid (cycle after grant)
//  pe1_rdata      out  DATA_W  PE1 load data
//  pe2_*          (same seven signals for PE2)
//  mem_en         out  1       memory access strobe
//  mem_we         out  1       memory write enable
//  mem_addr       out  ADDR_W  memory address
//  mem_wdata      out  DATA_W  memory write data
//  mem_rdata      in   DATA_W  memory read data; valid the cycle after mem_en & !mem_we
//  pe1_stall_cnt  out  CNT_W   cycles PE1 had req=1 and ready=0, saturating
//  pe2_stall_cnt  out  CNT_W   same for PE2
// BEHAVIOUR
//  Reset (rst=1 at edge): prio pointer = PE1, resp state = RESP_IDLE, stall counters = 0.
//   While rst=1: pe*_ready, pe*_rvalid, mem_en, mem_we forced 0.
//  Grant (combinational, same cycle):
//   - only pe1_req -> PE1; only pe2_req -> PE2
//   - both -> owner of prio pointer
//   - grant drives peX_ready=1 and mem_en=1, mem_we/addr/wdata = granted PE's signals
//   - no req -> mem_en=0, mem_we=0, mem_addr/wdata = 0
//  Prio pointer: after any grant, points to the non-granted PE; unchanged on idle cycles.
//  Response FSM (registered): RESP_IDLE / RESP_PE1 / RESP_PE2.
//   - next = RESP_PEx when a PEx load is granted, else RESP_IDLE
//   - in RESP_PEx: peX_rvalid=1, peX_rdata=mem_rdata; the other PE's rdata=0, rvalid=0
//   - stores never produce rvalid
//  Load latency 1 cycle after ready; back-to-back grants every cycle, no bubbles.
//  Simultaneous events:
//   - response to PEx and new grant to PEy in the same cycle are independent
//   - same PE may be granted in its own rvalid cycle
//  Stall counter: +1 per cycle with req&!ready, holds at 2^CNT_W-1, never wraps.
//  Reset mid-operation: an in-flight load is dropped; no rvalid in the cycle after rst deasserts.
//  req deasserted before ready: request withdrawn, no side effects. Same-cycle store and load
//   to the same address from different PEs are serialized in grant order.
// STRUCTURE
//  Package dual_pe_mem_pkg:
//   - ADDR_W/DATA_W defaults
//   - pe_id_t {PE1, PE2}
//   - resp_state_t {RESP_IDLE, RESP_PE1, RESP_PE2}
//  Sub-module rr_arbiter_2: 2-way round-robin with registered prio pointer; inputs req[1:0];
//   outputs one-hot gnt[1:0].
//  Top contains request mux, response FSM, stall counters.
// TESTING
//  1. rst 1->0, no reqs, 3 cycles -> mem_en=0, all ready/rvalid=0, counters=0.
//  2. PE1 load 0x10 (mem holds 0xDEADBEEF) -> pe1_ready cycle N;
//     pe1_rvalid=1, pe1_rdata=0xDEADBEEF cycle N+1; pe2_rvalid=0.
//  3. Both req every cycle for 4 cycles -> grants PE1,PE2,PE1,PE2.
//     Each stall_cnt increments on the other PE's grant cycles.
//  4. PE2 store 0x20 <- 0x1234 while PE1 load 0x20 simultaneously, prio=PE2 ->
//     PE2 granted first, PE1 next cycle reads 0x1234.
//  5. PE1 load granted, rst=1 on next edge -> no pe1_rvalid after reset; resp state RESP_IDLE.
//  6. CNT_W=4, PE2 held off 20 cycles (PE1 prio via forced pattern) -> pe2_stall_cnt saturates at 15.

Source files
------------

// File: rtl/dual_pe_mem_pkg.sv
// Shared types and default widths for the dual-PE shared data-memory arbiter.
package dual_pe_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic {
    PE1 = 1'b0,
    PE2 = 1'b1
  } pe_id_t;

  typedef enum logic [1:0] {
    RESP_IDLE = 2'd0,
    RESP_PE1  = 2'd1,
    RESP_PE2  = 2'd2
  } resp_state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: req[0]/gnt[0] is PE1, req[1]/gnt[1] is PE2.
module rr_arbiter_2
  import dual_pe_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  pe_id_t prio_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (prio_q == PE1) ? 2'b01 : 2'b10;
    end
  end

  // Priority moves to the losing side after every grant; idle cycles leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= PE1;
    end else if (gnt[0]) begin
      prio_q <= PE2;
    end else if (gnt[1]) begin
      prio_q <= PE1;
    end
  end

endmodule

// File: rtl/dual_pe_mem_arbiter.sv
// Merges PE1/PE2 load/store requests onto one single-port data memory with
// round-robin arbitration, routed read responses and saturating stall counters.
module dual_pe_mem_arbiter
  import dual_pe_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pe1_req,
  input  logic              pe1_we,
  input  logic [ADDR_W-1:0] pe1_addr,
  input  logic [DATA_W-1:0] pe1_wdata,
  output logic              pe1_ready,
  output logic              pe1_rvalid,
  output logic [DATA_W-1:0] pe1_rdata,
  input  logic              pe2_req,
  input  logic              pe2_we,
  input  logic [ADDR_W-1:0] pe2_addr,
  input  logic [DATA_W-1:0] pe2_wdata,
  output logic              pe2_ready,
  output logic              pe2_rvalid,
  output logic [DATA_W-1:0] pe2_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  pe1_stall_cnt,
  output logic [CNT_W-1:0]  pe2_stall_cnt
);

  logic [1:0]  req_v;
  logic [1:0]  gnt;
  resp_state_t resp_q, resp_d;

  // Masking requests during reset keeps every grant-derived output low.
  assign req_v = rst ? 2'b00 : {pe2_req, pe1_req};

  rr_arbiter_2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_v),
    .gnt (gnt)
  );

  assign pe1_ready = gnt[0];
  assign pe2_ready = gnt[1];

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[0]) begin
      mem_en    = 1'b1;
      mem_we    = pe1_we;
      mem_addr  = pe1_addr;
      mem_wdata = pe1_wdata;
    end else if (gnt[1]) begin
      mem_en    = 1'b1;
      mem_we    = pe2_we;
      mem_addr  = pe2_addr;
      mem_wdata = pe2_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q <= RESP_IDLE;
    end else begin
      resp_q <= resp_d;
    end
  end

  always_comb begin
    resp_d = RESP_IDLE;
    if (gnt[0] && !pe1_we) begin
      resp_d = RESP_PE1;
    end else if (gnt[1] && !pe2_we) begin
      resp_d = RESP_PE2;
    end
    pe1_rvalid = 1'b0;
    pe2_rvalid = 1'b0;
    pe1_rdata  = '0;
    pe2_rdata  = '0;
    if (!rst) begin
      case (resp_q)
        RESP_PE1: begin
          pe1_rvalid = 1'b1;
          pe1_rdata  = mem_rdata;
        end
        RESP_PE2: begin
          pe2_rvalid = 1'b1;
          pe2_rdata  = mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pe1_stall_cnt <= '0;
      pe2_stall_cnt <= '0;
    end else begin
      if (pe1_req && !gnt[0] && (pe1_stall_cnt != '1)) begin
        pe1_stall_cnt <= pe1_stall_cnt + 1'b1;
      end
      if (pe2_req && !gnt[1] && (pe2_stall_cnt != '1)) begin
        pe2_stall_cnt <= pe2_stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dual_pe_mem_arbiter.sv
// Bench for dual_pe_mem_arbiter: behavioural model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_dual_pe_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pe1_req, pe1_we, pe2_req, pe2_we;
  logic [31:0] pe1_addr, pe1_wdata, pe2_addr, pe2_wdata;
  logic        pe1_ready, pe1_rvalid, pe2_ready, pe2_rvalid;
  logic [31:0] pe1_rdata, pe2_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [15:0] pe1_stall_cnt, pe2_stall_cnt;

  // Second instance with narrow counters for saturation.
  logic        s_rst, s_req1, s_req2;
  logic        s_rdy1, s_rv1, s_rdy2, s_rv2, s_en, s_we;
  logic [31:0] s_rd1, s_rd2, s_addr, s_wdata;
  logic [3:0]  s_cnt1, s_cnt2;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  dual_pe_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .pe1_req(pe1_req), .pe1_we(pe1_we), .pe1_addr(pe1_addr), .pe1_wdata(pe1_wdata),
    .pe1_ready(pe1_ready), .pe1_rvalid(pe1_rvalid), .pe1_rdata(pe1_rdata),
    .pe2_req(pe2_req), .pe2_we(pe2_we), .pe2_addr(pe2_addr), .pe2_wdata(pe2_wdata),
    .pe2_ready(pe2_ready), .pe2_rvalid(pe2_rvalid), .pe2_rdata(pe2_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pe1_stall_cnt(pe1_stall_cnt), .pe2_stall_cnt(pe2_stall_cnt)
  );

  dual_pe_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) u_sat (
    .clk(clk), .rst(s_rst),
    .pe1_req(s_req1), .pe1_we(1'b0), .pe1_addr(32'h40), .pe1_wdata(32'h0),
    .pe1_ready(s_rdy1), .pe1_rvalid(s_rv1), .pe1_rdata(s_rd1),
    .pe2_req(s_req2), .pe2_we(1'b0), .pe2_addr(32'h44), .pe2_wdata(32'h0),
    .pe2_ready(s_rdy2), .pe2_rvalid(s_rv2), .pe2_rdata(s_rd2),
    .mem_en(s_en), .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
    .mem_rdata(32'h0), .pe1_stall_cnt(s_cnt1), .pe2_stall_cnt(s_cnt2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end else begin
      passes++;
    end
  endtask

  // Environment memory: 1-cycle read latency, driven by the DUT's memory bus.
  logic [31:0] envmem [logic [31:0]];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) envmem[mem_addr] = mem_wdata;
      else mem_rdata <= envmem.exists(mem_addr) ? envmem[mem_addr] : 32'h0;
    end
  end

  // Behavioural model: who wins, what comes back when, and how long each PE waited.
  logic [31:0] shadow [logic [31:0]];
  int          m_prio = 1;
  int          m_pend = 0;
  logic [31:0] m_pend_data = '0;
  int          m_c1 = 0, m_c2 = 0;
  bit          m_valid = 0;
  int          g;
  logic        e_we;
  logic [31:0] e_addr, e_wdata;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_pe1_ready", pe1_ready, 0);
      chk("rst_pe2_ready", pe2_ready, 0);
      chk("rst_pe1_rvalid", pe1_rvalid, 0);
      chk("rst_pe2_rvalid", pe2_rvalid, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      m_prio = 1; m_pend = 0; m_c1 = 0; m_c2 = 0; m_valid = 1;
    end else if (m_valid) begin
      if (pe1_req && pe2_req) g = m_prio;
      else if (pe1_req) g = 1;
      else if (pe2_req) g = 2;
      else g = 0;
      e_we    = (g == 1) ? pe1_we : (g == 2) ? pe2_we : 1'b0;
      e_addr  = (g == 1) ? pe1_addr : (g == 2) ? pe2_addr : 32'h0;
      e_wdata = (g == 1) ? pe1_wdata : (g == 2) ? pe2_wdata : 32'h0;
      chk("m_pe1_ready", pe1_ready, (g == 1));
      chk("m_pe2_ready", pe2_ready, (g == 2));
      chk("m_mem_en", mem_en, (g != 0));
      chk("m_mem_we", mem_we, e_we);
      chk("m_mem_addr", mem_addr, e_addr);
      chk("m_mem_wdata", mem_wdata, e_wdata);
      chk("m_pe1_rvalid", pe1_rvalid, (m_pend == 1));
      chk("m_pe2_rvalid", pe2_rvalid, (m_pend == 2));
      chk("m_pe1_rdata", pe1_rdata, (m_pend == 1) ? m_pend_data : 32'h0);
      chk("m_pe2_rdata", pe2_rdata, (m_pend == 2) ? m_pend_data : 32'h0);
      chk("m_pe1_stall", pe1_stall_cnt, m_c1);
      chk("m_pe2_stall", pe2_stall_cnt, m_c2);
      if (pe1_req && g != 1 && m_c1 < 65535) m_c1++;
      if (pe2_req && g != 2 && m_c2 < 65535) m_c2++;
      m_pend = 0;
      if (g != 0) begin
        m_prio = (g == 1) ? 2 : 1;
        if (e_we) begin
          shadow[e_addr] = e_wdata;
        end else begin
          m_pend = g;
          m_pend_data = shadow.exists(e_addr) ? shadow[e_addr] : 32'h0;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst = 1; s_rst = 1; s_req1 = 0; s_req2 = 0;
    pe1_req = 0; pe1_we = 0; pe1_addr = '0; pe1_wdata = '0;
    pe2_req = 0; pe2_we = 0; pe2_addr = '0; pe2_wdata = '0;
    envmem[32'h10] = 32'hDEADBEEF;
    shadow[32'h10] = 32'hDEADBEEF;
    repeat (2) tick;
    rst = 0;

    // 1: idle after reset
    repeat (3) begin
      @(negedge clk);
      chk("t1_mem_en", mem_en, 0);
    end
    chk("t1_cnt1", pe1_stall_cnt, 0);
    chk("t1_cnt2", pe2_stall_cnt, 0);

    // 2: PE1 load 0x10
    tick; pe1_req = 1; pe1_we = 0; pe1_addr = 32'h10;
    @(negedge clk); chk("t2_pe1_ready", pe1_ready, 1);
    tick; pe1_req = 0;
    @(negedge clk);
    chk("t2_pe1_rvalid", pe1_rvalid, 1);
    chk("t2_pe1_rdata", pe1_rdata, 32'hDEADBEEF);
    chk("t2_pe2_rvalid", pe2_rvalid, 0);

    // PE2 alone, handing priority back to PE1
    tick; pe2_req = 1; pe2_we = 0; pe2_addr = 32'h10;
    @(negedge clk); chk("t3_pre_pe2_ready", pe2_ready, 1);
    tick; pe2_req = 0;

    // 3: both requesting for 4 cycles
    pe1_req = 1; pe1_addr = 32'h10; pe2_req = 1; pe2_addr = 32'h14;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_pe1_ready", pe1_ready, (i % 2 == 0));
      chk("t3_pe2_ready", pe2_ready, (i % 2 == 1));
      tick;
    end
    pe1_req = 0; pe2_req = 0;
    @(negedge clk);
    chk("t3_cnt1", pe1_stall_cnt, 2);
    chk("t3_cnt2", pe2_stall_cnt, 2);

    // PE1 store alone so priority sits with PE2
    tick; pe1_req = 1; pe1_we = 1; pe1_addr = 32'h30; pe1_wdata = 32'h55;
    @(negedge clk); chk("t4_pre_pe1_ready", pe1_ready, 1);

    // 4: PE2 store and PE1 load to 0x20 together
    tick;
    pe1_we = 0; pe1_addr = 32'h20;
    pe2_req = 1; pe2_we = 1; pe2_addr = 32'h20; pe2_wdata = 32'h1234;
    @(negedge clk);
    chk("t4_pe2_ready", pe2_ready, 1);
    chk("t4_pe1_ready0", pe1_ready, 0);
    chk("t4_mem_we", mem_we, 1);
    tick; pe2_req = 0; pe2_we = 0;
    @(negedge clk); chk("t4_pe1_ready1", pe1_ready, 1);
    tick; pe1_req = 0;
    @(negedge clk);
    chk("t4_pe1_rvalid", pe1_rvalid, 1);
    chk("t4_pe1_rdata", pe1_rdata, 32'h1234);
    chk("t4_pe2_rvalid", pe2_rvalid, 0);
    chk("t4_cnt1", pe1_stall_cnt, 3);

    // 5: reset right after a PE1 load grant
    tick; pe1_req = 1; pe1_we = 0; pe1_addr = 32'h10;
    @(negedge clk); chk("t5_pe1_ready", pe1_ready, 1);
    tick; pe1_req = 0; rst = 1;
    @(negedge clk); chk("t5_rvalid_in_rst", pe1_rvalid, 0);
    tick; rst = 0;
    @(negedge clk);
    chk("t5_rvalid_after", pe1_rvalid, 0);
    chk("t5_pe2_rvalid", pe2_rvalid, 0);
    chk("t5_cnt1", pe1_stall_cnt, 0);

    // 6: 4-bit counters saturate under continuous contention
    tick; s_rst = 0; s_req1 = 1; s_req2 = 1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t6_cnt1_mid", s_cnt1, 5);
    chk("t6_cnt2_mid", s_cnt2, 5);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("t6_cnt1_sat", s_cnt1, 15);
    chk("t6_cnt2_sat", s_cnt2, 15);

    repeat (3) tick;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
